matmul_tile_sequencer: RTL and testbench

Runtime-configurable tiling controller for the systolic matmul accelerator. It breaks an arbitrary M x K activation by K x N weight product into SYS_ROWS x SYS_COLS array passes and issues one command per tile pass over a valid/ready interface. Weight loader, activation streamer and accumulator consume these commands. Unlike fixed compile-time tiling, it accepts sizes that are not multiples of the array (ragged edge tiles) and offers a selectable loop order that enables weight reuse.

---
 rtl/matmul_tile_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_matmul_tile_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_tile_sequencer.sv
// Tiling controller for the systolic matmul array.
// Walks M/K/N tile indices and issues one command per array pass.
module matmul_tile_sequencer #(
    parameter int SYS_ROWS    = 50,
    parameter int SYS_COLS    = 50,
    parameter int A_TILE_ROWS = 50,
    parameter int ACC_TILES   = 1,
    parameter int DIM_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] cfg_m,
    input  logic [DIM_W-1:0] cfg_k,
    input  logic [DIM_W-1:0] cfg_n,
    input  logic             cfg_order,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [DIM_W-1:0] cmd_m_idx,
    output logic [DIM_W-1:0] cmd_k_idx,
    output logic [DIM_W-1:0] cmd_n_idx,
    output logic [DIM_W-1:0] cmd_rows,
    output logic [DIM_W-1:0] cmd_kdim,
    output logic [DIM_W-1:0] cmd_cols,
    output logic             cmd_load_w,
    output logic             cmd_acc_clear,
    output logic             cmd_acc_last
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ISSUE, S_DONE} state_t;

    localparam logic [DIM_W-1:0] TM = DIM_W'(A_TILE_ROWS);
    localparam logic [DIM_W-1:0] TK = DIM_W'(SYS_ROWS);
    localparam logic [DIM_W-1:0] TN = DIM_W'(SYS_COLS);
    localparam logic [DIM_W:0]   TM1 = (DIM_W+1)'(A_TILE_ROWS);
    localparam logic [DIM_W:0]   TK1 = (DIM_W+1)'(SYS_ROWS);
    localparam logic [DIM_W:0]   TN1 = (DIM_W+1)'(SYS_COLS);
    localparam logic [DIM_W:0]   ACC = (DIM_W+1)'(ACC_TILES);

    state_t           state_q;
    logic [DIM_W-1:0] m_cfg_q, k_cfg_q, n_cfg_q;
    logic             ord_q;
    logic [DIM_W-1:0] mi_q, ki_q, ni_q;
    logic [DIM_W-1:0] mi_d, ki_d, ni_d;
    logic             busy_q, done_q, err_q, valid_q;
    logic [DIM_W-1:0] rows_q, kdim_q, cols_q;
    logic             load_q, clr_q, last_q;

    logic [DIM_W:0] mt_w, kt_w, nt_w;
    logic           m_last, k_last, n_last;
    logic           dm_last, dk_last, dn_last;
    logic           cfg_bad, fire, all_last;

    // Valid extent of a tile: full size except on the ragged last tile.
    function automatic logic [DIM_W-1:0] ext(
        input logic [DIM_W-1:0] x,
        input logic [DIM_W-1:0] idx,
        input logic             is_last,
        input logic [DIM_W-1:0] t
    );
        return is_last ? (x - idx * t) : t;
    endfunction

    // Tile counts, one bit wider so the round-up add cannot overflow.
    assign mt_w = ({1'b0, m_cfg_q} + TM1 - 1'b1) / TM1;
    assign kt_w = ({1'b0, k_cfg_q} + TK1 - 1'b1) / TK1;
    assign nt_w = ({1'b0, n_cfg_q} + TN1 - 1'b1) / TN1;

    assign m_last   = ({1'b0, mi_q} == mt_w - 1'b1);
    assign k_last   = ({1'b0, ki_q} == kt_w - 1'b1);
    assign n_last   = ({1'b0, ni_q} == nt_w - 1'b1);
    assign all_last = m_last & k_last & n_last;
    assign fire     = valid_q & cmd_ready;

    assign cfg_bad = (m_cfg_q == '0) || (k_cfg_q == '0) || (n_cfg_q == '0) ||
                     (ord_q && (mt_w > ACC));

    // Next tile indices; outside ISSUE this is the first tile (0,0,0).
    always_comb begin
        mi_d = '0;
        ki_d = '0;
        ni_d = '0;
        if (state_q == S_ISSUE) begin
            mi_d = mi_q;
            ki_d = ki_q;
            ni_d = ni_q;
            if (!ord_q) begin
                if (k_last) begin
                    ki_d = '0;
                    if (m_last) begin
                        mi_d = '0;
                        ni_d = ni_q + 1'b1;
                    end else begin
                        mi_d = mi_q + 1'b1;
                    end
                end else begin
                    ki_d = ki_q + 1'b1;
                end
            end else begin
                if (m_last) begin
                    mi_d = '0;
                    if (k_last) begin
                        ki_d = '0;
                        ni_d = ni_q + 1'b1;
                    end else begin
                        ki_d = ki_q + 1'b1;
                    end
                end else begin
                    mi_d = mi_q + 1'b1;
                end
            end
        end
    end

    assign dm_last = ({1'b0, mi_d} == mt_w - 1'b1);
    assign dk_last = ({1'b0, ki_d} == kt_w - 1'b1);
    assign dn_last = ({1'b0, ni_d} == nt_w - 1'b1);

    // Control FSM; every output is registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            m_cfg_q <= '0;
            k_cfg_q <= '0;
            n_cfg_q <= '0;
            ord_q   <= 1'b0;
            mi_q    <= '0;
            ki_q    <= '0;
            ni_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            rows_q  <= '0;
            kdim_q  <= '0;
            cols_q  <= '0;
            load_q  <= 1'b0;
            clr_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        m_cfg_q <= cfg_m;
                        k_cfg_q <= cfg_k;
                        n_cfg_q <= cfg_n;
                        ord_q   <= cfg_order;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP, S_ISSUE: begin
                    if (state_q == S_SETUP && cfg_bad) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (state_q == S_ISSUE && fire && all_last) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (state_q == S_SETUP || fire) begin
                        valid_q <= 1'b1;
                        mi_q    <= mi_d;
                        ki_q    <= ki_d;
                        ni_q    <= ni_d;
                        rows_q  <= ext(m_cfg_q, mi_d, dm_last, TM);
                        kdim_q  <= ext(k_cfg_q, ki_d, dk_last, TK);
                        cols_q  <= ext(n_cfg_q, ni_d, dn_last, TN);
                        load_q  <= !ord_q || (mi_d == '0);
                        clr_q   <= (ki_d == '0);
                        last_q  <= dk_last;
                        state_q <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign cmd_valid     = valid_q;
    assign cmd_m_idx     = mi_q;
    assign cmd_k_idx     = ki_q;
    assign cmd_n_idx     = ni_q;
    assign cmd_rows      = rows_q;
    assign cmd_kdim      = kdim_q;
    assign cmd_cols      = cols_q;
    assign cmd_load_w    = load_q;
    assign cmd_acc_clear = clr_q;
    assign cmd_acc_last  = last_q;

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Scoreboard bench for matmul_tile_sequencer.
// Expected commands are queued at start and popped on each fire.
module tb_matmul_tile_sequencer;

    localparam int DW = 16;
    localparam int T  = 4;

    logic          clk = 1'b0;
    logic          rst, start, cfg_order, cmd_ready;
    logic [DW-1:0] cfg_m, cfg_k, cfg_n;
    logic          busy, done, err, cmd_valid;
    logic [DW-1:0] cmd_m_idx, cmd_k_idx, cmd_n_idx;
    logic [DW-1:0] cmd_rows, cmd_kdim, cmd_cols;
    logic          cmd_load_w, cmd_acc_clear, cmd_acc_last;

    matmul_tile_sequencer #(
        .SYS_ROWS(T), .SYS_COLS(T), .A_TILE_ROWS(T),
        .ACC_TILES(2), .DIM_W(DW)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n),
        .cfg_order(cfg_order),
        .busy(busy), .done(done), .err(err),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_m_idx(cmd_m_idx), .cmd_k_idx(cmd_k_idx),
        .cmd_n_idx(cmd_n_idx), .cmd_rows(cmd_rows),
        .cmd_kdim(cmd_kdim), .cmd_cols(cmd_cols),
        .cmd_load_w(cmd_load_w), .cmd_acc_clear(cmd_acc_clear),
        .cmd_acc_last(cmd_acc_last)
    );

    always #5 clk = ~clk;

    typedef logic [99:0] cmd_t;

    cmd_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   fires = 0;
    int   last_fire_cyc = -100;
    int   ready_mode = 0;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic cmd_t mk(input int m, k, n, mi, ki, ni,
                                input int mt, kt, nt, ord);
        logic [DW-1:0] r, kd, c;
        logic ld, cl, la;
        r  = DW'((mi == mt - 1) ? m - mi * T : T);
        kd = DW'((ki == kt - 1) ? k - ki * T : T);
        c  = DW'((ni == nt - 1) ? n - ni * T : T);
        ld = (ord == 0) || (mi == 0);
        cl = (ki == 0);
        la = (ki == kt - 1);
        return {1'b1, DW'(mi), DW'(ki), DW'(ni), r, kd, c, ld, cl, la};
    endfunction

    task automatic build(input int m, k, n, ord);
        int mt, kt, nt;
        mt = (m + T - 1) / T;
        kt = (k + T - 1) / T;
        nt = (n + T - 1) / T;
        for (int ni = 0; ni < nt; ni++) begin
            if (ord == 0) begin
                for (int mi = 0; mi < mt; mi++)
                    for (int ki = 0; ki < kt; ki++)
                        exp_q.push_back(mk(m, k, n, mi, ki, ni, mt, kt, nt, ord));
            end else begin
                for (int ki = 0; ki < kt; ki++)
                    for (int mi = 0; mi < mt; mi++)
                        exp_q.push_back(mk(m, k, n, mi, ki, ni, mt, kt, nt, ord));
            end
        end
    endtask

    function automatic cmd_t cur();
        return {cmd_valid, cmd_m_idx, cmd_k_idx, cmd_n_idx, cmd_rows,
                cmd_kdim, cmd_cols, cmd_load_w, cmd_acc_clear, cmd_acc_last};
    endfunction

    // Cycle counter.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Ready driver, changes just after each rising edge.
    initial begin
        cmd_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: cmd_ready = 1'b1;
                1: cmd_ready = 1'($urandom_range(0, 1));
                default: begin
                    int rel;
                    rel = cyc - start_cyc;
                    cmd_ready = !(rel >= 4 && rel <= 8);
                end
            endcase
        end
    end

    // Monitor: score fires, check field hold under backpressure.
    initial begin
        cmd_t prev;
        bit   prev_stall;
        prev = '0;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    check("hold", cur(), prev);
                if (cmd_valid && cmd_ready) begin
                    fires++;
                    last_fire_cyc = cyc;
                    if (exp_q.size() == 0)
                        check("extra_cmd", cur(), '0);
                    else
                        check("cmd", cur(), exp_q.pop_front());
                end
                prev_stall = cmd_valid && !cmd_ready;
                prev = cur();
            end
        end
    end

    task automatic kick(input int m, k, n, ord);
        @(posedge clk);
        #1;
        cfg_m = DW'(m);
        cfg_k = DW'(k);
        cfg_n = DW'(n);
        cfg_order = ord[0];
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        cfg_m = 16'd1;
        cfg_k = 16'd1;
        cfg_n = 16'd1;
        cfg_order = 1'b0;
    endtask

    task automatic run(input int m, k, n, ord, mode,
                       input bit exp_err, input bit inject);
        int  n_exp;
        bit  got_done;
        exp_q.delete();
        if (!exp_err)
            build(m, k, n, ord);
        n_exp = exp_q.size();
        fires = 0;
        last_fire_cyc = -100;
        ready_mode = mode;
        kick(m, k, n, ord);
        got_done = 1'b0;
        for (int i = 0; i < 600 && !got_done; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("setup_busy", busy, 1);
                check("setup_valid", cmd_valid, 0);
                check("err_clr", err, 0);
            end
            if (i == 1)
                check("first_valid", cmd_valid, !exp_err);
            if (inject && i == 4)
                start = 1'b1;
            if (inject && i == 5)
                start = 1'b0;
            if (done) begin
                got_done = 1'b1;
                check("done_busy", busy, 0);
                check("err", err, exp_err);
                check("fires", fires, n_exp);
                check("q_empty", exp_q.size(), 0);
                if (n_exp > 0)
                    check("done_lat", cyc - last_fire_cyc, 1);
            end
        end
        start = 1'b0;
        if (!got_done)
            check("timeout", 0, 1);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("idle_busy", busy, 0);
        check("idle_valid", cmd_valid, 0);
        check("err_hold", err, exp_err);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cfg_m = '0;
        cfg_k = '0;
        cfg_n = '0;
        cfg_order = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", {busy, done, err, cur()}, '0);
        rst = 1'b0;

        run(4, 4, 4, 0, 0, 1'b0, 1'b0);
        run(6, 8, 5, 0, 0, 1'b0, 1'b0);
        run(6, 8, 5, 1, 0, 1'b0, 1'b0);
        run(12, 4, 4, 1, 0, 1'b1, 1'b0);
        run(4, 0, 4, 0, 0, 1'b1, 1'b0);
        run(4, 4, 4, 0, 0, 1'b0, 1'b0);
        run(6, 8, 5, 0, 2, 1'b0, 1'b0);
        run(7, 9, 10, 1, 1, 1'b0, 1'b0);
        run(5, 6, 7, 0, 1, 1'b0, 1'b0);
        run(8, 7, 9, 1, 1, 1'b0, 1'b1);
        run(13, 1, 3, 0, 1, 1'b0, 1'b0);

        exp_q.delete();
        build(9, 9, 9, 0);
        ready_mode = 1;
        kick(9, 9, 9, 0);
        repeat (6) @(negedge clk);
        check("mid_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", {busy, done, err, cur()}, '0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_done", {busy, done, cmd_valid}, '0);
        end

        run(9, 9, 9, 0, 1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
